f2d_pipe_reg: RTL and testbench
===============================

F2D_PIPE_REG -- requirements
Module: f2d_pipe_reg

Interface
REQ-001 SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-002 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-003 SHALL have port intReq  input  1  exception/interrupt entry; insert bubble tagged with handler PC.
REQ-004 SHALL have port flush  input  1  eret/kill; insert bubble carrying F_pc.
REQ-005 SHALL have port stall  input  1  hold all D-stage state.
REQ-006 SHALL have port F_pc  input  32  fetch-stage PC from IFU.
REQ-007 SHALL have port F_instr  input  32  instruction word read at F_pc.
REQ-008 SHALL have port F_exCode  input  5  fetch exception code (0 = none, 5'h4 = AdEL).
REQ-009 SHALL have port F_bd  input  1  fetched instruction sits in a branch delay slot.
REQ-010 SHALL have ports D_pc (output, 32), D_instr (output, 32), D_exCode (output, 5), D_bd (output, 1), D_valid (output, 1): decode-stage copies; D_valid = 1 means a real fetched instruction.
REQ-011 SHALL have ports D_stallCnt (output, 16) and D_bubbleCnt (output, 16): performance counters (see Configuration).

Function
REQ-012 SHALL update state per cycle with strict priority: reset > intReq > flush > stall > load.
REQ-013 On intReq SHALL set D_pc=32'h0000_4180, D_instr=0, D_exCode=0, D_bd=0, D_valid=0, regardless of stall/flush.
REQ-014 On flush (no intReq) SHALL set D_pc=F_pc, D_instr=0, D_exCode=0, D_bd=0, D_valid=0; flush overrides stall.
REQ-015 On stall (no intReq/flush) SHALL hold D_pc, D_instr, D_exCode, D_bd, D_valid unchanged.
REQ-016 On load SHALL capture D_pc=F_pc, D_exCode=F_exCode, D_bd=F_bd, D_valid=1, one cycle latency.
REQ-017 On load with F_exCode!=0 SHALL force D_instr=0 (nop), so the faulting word is never decoded; otherwise D_instr=F_instr.
REQ-018 Outputs SHALL be driven directly from registers; no combinational path from inputs to outputs.
REQ-019 Bubbles SHALL always carry a valid PC (4180 or F_pc) so downstream EPC capture is well-defined.

Reset
REQ-020 On reset SHALL set D_pc=32'h0000_3000, D_instr=0, D_exCode=0, D_bd=0, D_valid=0, D_stallCnt=0, D_bubbleCnt=0.
REQ-021 Reset SHALL override intReq, flush and stall in the same cycle.

Configuration
REQ-022 Macro F2D_PERF_CNT_EN SHALL control the performance counters.
REQ-023 With F2D_PERF_CNT_EN defined: D_stallCnt SHALL increment by 1 per cycle where stall is honoured (REQ-015 branch taken), saturating at 16'hFFFF.
REQ-024 With F2D_PERF_CNT_EN defined: D_bubbleCnt SHALL increment by 1 per cycle where intReq or flush is honoured, saturating at 16'hFFFF.
REQ-025 Without F2D_PERF_CNT_EN: D_stallCnt and D_bubbleCnt SHALL be constant 0, no counter flops synthesised; all other behaviour identical.

Verification
REQ-026 Reset 1 cycle, then F_pc=0x3000, F_instr=0x3C01_1234, F_exCode=0 -> after reset D_pc=0x3000, D_valid=0; next edge D_pc=0x3000, D_instr=0x3C01_1234, D_valid=1.
REQ-027 Load F_pc=0x3004, then stall=1 for 3 cycles while F_pc changes to 0x3008 -> D_pc stays 0x3004 for 3 cycles; D_stallCnt=3 (macro on) / 0 (macro off).
REQ-028 F_pc=0x3002, F_instr=0xFFFF_FFFF, F_exCode=5'h4 -> D_instr=0, D_exCode=5'h4, D_valid=1, D_pc=0x3002.
REQ-029 stall=1, flush=1, F_pc=0x3010 same cycle -> D_pc=0x3010, D_instr=0, D_valid=0; D_bubbleCnt +1, D_stallCnt unchanged.
REQ-030 intReq=1 with flush=1, stall=1, F_bd=1 -> D_pc=0x4180, D_bd=0, D_valid=0; same cycle with reset=1 -> D_pc=0x3000.
REQ-031 Macro on, stall held 65 540 cycles -> D_stallCnt saturates at 0xFFFF and stays there.

Source files
------------

// File: rtl/f2d_pipe_reg.sv
// Fetch-to-decode pipeline register with interrupt/flush bubble insertion and stall hold.
// Optional stall/bubble performance counters are compiled in when F2D_PERF_CNT_EN is defined.
module f2d_pipe_reg (
  input  logic        clk,
  input  logic        reset,
  input  logic        intReq,
  input  logic        flush,
  input  logic        stall,
  input  logic [31:0] F_pc,
  input  logic [31:0] F_instr,
  input  logic [4:0]  F_exCode,
  input  logic        F_bd,
  output logic [31:0] D_pc,
  output logic [31:0] D_instr,
  output logic [4:0]  D_exCode,
  output logic        D_bd,
  output logic        D_valid,
  output logic [15:0] D_stallCnt,
  output logic [15:0] D_bubbleCnt
);

  localparam logic [31:0] RESET_PC   = 32'h0000_3000;
  localparam logic [31:0] HANDLER_PC = 32'h0000_4180;

  logic [31:0] pc_reg, pc_next;
  logic [31:0] instr_reg, instr_next;
  logic [4:0]  excode_reg, excode_next;
  logic        bd_reg, bd_next;
  logic        valid_reg, valid_next;

  logic        bubble_taken;
  logic        stall_taken;

  assign bubble_taken = intReq | flush;
  assign stall_taken  = stall & ~bubble_taken;

  always_comb begin
    pc_next     = pc_reg;
    instr_next  = instr_reg;
    excode_next = excode_reg;
    bd_next     = bd_reg;
    valid_next  = valid_reg;
    if (intReq) begin
      pc_next     = HANDLER_PC;
      instr_next  = 32'h0;
      excode_next = 5'h0;
      bd_next     = 1'b0;
      valid_next  = 1'b0;
    end else if (flush) begin
      // Bubble keeps the fetch PC so a later EPC capture still sees a real address
      pc_next     = F_pc;
      instr_next  = 32'h0;
      excode_next = 5'h0;
      bd_next     = 1'b0;
      valid_next  = 1'b0;
    end else if (!stall) begin
      pc_next     = F_pc;
      instr_next  = (F_exCode != 5'h0) ? 32'h0 : F_instr;
      excode_next = F_exCode;
      bd_next     = F_bd;
      valid_next  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_reg     <= RESET_PC;
      instr_reg  <= 32'h0;
      excode_reg <= 5'h0;
      bd_reg     <= 1'b0;
      valid_reg  <= 1'b0;
    end else begin
      pc_reg     <= pc_next;
      instr_reg  <= instr_next;
      excode_reg <= excode_next;
      bd_reg     <= bd_next;
      valid_reg  <= valid_next;
    end
  end

  assign D_pc     = pc_reg;
  assign D_instr  = instr_reg;
  assign D_exCode = excode_reg;
  assign D_bd     = bd_reg;
  assign D_valid  = valid_reg;

`ifdef F2D_PERF_CNT_EN
  logic [15:0] stall_cnt_reg, stall_cnt_next;
  logic [15:0] bubble_cnt_reg, bubble_cnt_next;

  // Both counters saturate rather than wrap
  always_comb begin
    stall_cnt_next  = stall_cnt_reg;
    bubble_cnt_next = bubble_cnt_reg;
    if (stall_taken && stall_cnt_reg != 16'hFFFF)
      stall_cnt_next = stall_cnt_reg + 16'd1;
    if (bubble_taken && bubble_cnt_reg != 16'hFFFF)
      bubble_cnt_next = bubble_cnt_reg + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_reg  <= 16'h0;
      bubble_cnt_reg <= 16'h0;
    end else begin
      stall_cnt_reg  <= stall_cnt_next;
      bubble_cnt_reg <= bubble_cnt_next;
    end
  end

  assign D_stallCnt  = stall_cnt_reg;
  assign D_bubbleCnt = bubble_cnt_reg;
`else
  logic unused_taken;
  assign unused_taken = stall_taken;
  assign D_stallCnt   = 16'h0;
  assign D_bubbleCnt  = 16'h0;
`endif

endmodule

// File: tb/tb_f2d_pipe_reg.sv
// Directed self-checking bench for f2d_pipe_reg; counter expectations follow F2D_PERF_CNT_EN.
module tb_f2d_pipe_reg;

  logic        clk = 1'b0;
  logic        reset;
  logic        intReq;
  logic        flush;
  logic        stall;
  logic [31:0] F_pc;
  logic [31:0] F_instr;
  logic [4:0]  F_exCode;
  logic        F_bd;
  logic [31:0] D_pc;
  logic [31:0] D_instr;
  logic [4:0]  D_exCode;
  logic        D_bd;
  logic        D_valid;
  logic [15:0] D_stallCnt;
  logic [15:0] D_bubbleCnt;

  int errors = 0;
  int checks = 0;
  logic [15:0] exp_stall;
  logic [15:0] exp_bubble;

`ifdef F2D_PERF_CNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  f2d_pipe_reg dut (
    .clk(clk), .reset(reset), .intReq(intReq), .flush(flush), .stall(stall),
    .F_pc(F_pc), .F_instr(F_instr), .F_exCode(F_exCode), .F_bd(F_bd),
    .D_pc(D_pc), .D_instr(D_instr), .D_exCode(D_exCode), .D_bd(D_bd),
    .D_valid(D_valid), .D_stallCnt(D_stallCnt), .D_bubbleCnt(D_bubbleCnt)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; intReq = 1'b0; flush = 1'b0; stall = 1'b0;
    F_pc = 32'h3000; F_instr = 32'h3C01_1234; F_exCode = 5'h0; F_bd = 1'b0;
    step();
    step();
    exp_stall = 16'h0; exp_bubble = 16'h0;
    checks++; if (D_pc !== 32'h3000) begin errors++; $display("FAIL reset_pc got %h want %h", D_pc, 32'h3000); end
    checks++; if (D_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", D_valid); end
    checks++; if (D_instr !== 32'h0 || D_exCode !== 5'h0 || D_bd !== 1'b0) begin
      errors++; $display("FAIL reset_fields got instr=%h ex=%h bd=%b want 0", D_instr, D_exCode, D_bd); end
    checks++; if (D_stallCnt !== 16'h0 || D_bubbleCnt !== 16'h0) begin
      errors++; $display("FAIL reset_cnt got %h/%h want 0/0", D_stallCnt, D_bubbleCnt); end
    $display("test_reset: pc=%h valid=%b", D_pc, D_valid);
  endtask

  task automatic test_load();
    reset = 1'b0;
    step();
    checks++; if (D_pc !== 32'h3000) begin errors++; $display("FAIL load_pc got %h want %h", D_pc, 32'h3000); end
    checks++; if (D_instr !== 32'h3C01_1234) begin errors++; $display("FAIL load_instr got %h want %h", D_instr, 32'h3C01_1234); end
    checks++; if (D_valid !== 1'b1) begin errors++; $display("FAIL load_valid got %b want 1", D_valid); end
    $display("test_load: pc=%h instr=%h valid=%b", D_pc, D_instr, D_valid);
  endtask

  task automatic test_stall();
    F_pc = 32'h3004; F_instr = 32'h2421_0001; F_bd = 1'b1;
    step();
    checks++; if (D_pc !== 32'h3004 || D_bd !== 1'b1) begin
      errors++; $display("FAIL stall_preload got pc=%h bd=%b want 3004/1", D_pc, D_bd); end
    stall = 1'b1; F_pc = 32'h3008; F_instr = 32'h0000_0000; F_bd = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (CNT_ON) exp_stall++;
      checks++; if (D_pc !== 32'h3004 || D_instr !== 32'h2421_0001 || D_bd !== 1'b1 || D_valid !== 1'b1) begin
        errors++; $display("FAIL stall_hold[%0d] got pc=%h instr=%h bd=%b v=%b want 3004/24210001/1/1",
                           i, D_pc, D_instr, D_bd, D_valid); end
    end
    checks++; if (D_stallCnt !== exp_stall) begin errors++; $display("FAIL stall_cnt got %0d want %0d", D_stallCnt, exp_stall); end
    stall = 1'b0;
    step();
    checks++; if (D_pc !== 32'h3008 || D_bd !== 1'b0) begin
      errors++; $display("FAIL stall_release got pc=%h bd=%b want 3008/0", D_pc, D_bd); end
    $display("test_stall: pc=%h stallCnt=%0d", D_pc, D_stallCnt);
  endtask

  task automatic test_exc();
    F_pc = 32'h3002; F_instr = 32'hFFFF_FFFF; F_exCode = 5'h4;
    step();
    checks++; if (D_instr !== 32'h0) begin errors++; $display("FAIL exc_instr got %h want 0", D_instr); end
    checks++; if (D_exCode !== 5'h4 || D_valid !== 1'b1 || D_pc !== 32'h3002) begin
      errors++; $display("FAIL exc_fields got ex=%h v=%b pc=%h want 4/1/3002", D_exCode, D_valid, D_pc); end
    F_exCode = 5'h0;
    $display("test_exc: pc=%h instr=%h ex=%h", D_pc, D_instr, D_exCode);
  endtask

  task automatic test_flush_stall();
    stall = 1'b1; flush = 1'b1; F_pc = 32'h3010; F_instr = 32'h1234_5678; F_bd = 1'b1;
    step();
    if (CNT_ON) exp_bubble++;
    checks++; if (D_pc !== 32'h3010 || D_instr !== 32'h0 || D_valid !== 1'b0 || D_bd !== 1'b0 || D_exCode !== 5'h0) begin
      errors++; $display("FAIL flush_bubble got pc=%h instr=%h v=%b bd=%b want 3010/0/0/0", D_pc, D_instr, D_valid, D_bd); end
    checks++; if (D_bubbleCnt !== exp_bubble || D_stallCnt !== exp_stall) begin
      errors++; $display("FAIL flush_cnt got b=%0d s=%0d want b=%0d s=%0d", D_bubbleCnt, D_stallCnt, exp_bubble, exp_stall); end
    $display("test_flush_stall: pc=%h bubbleCnt=%0d", D_pc, D_bubbleCnt);
  endtask

  task automatic test_intreq();
    intReq = 1'b1; flush = 1'b1; stall = 1'b1; F_bd = 1'b1; F_pc = 32'h3020;
    step();
    if (CNT_ON) exp_bubble++;
    checks++; if (D_pc !== 32'h4180 || D_bd !== 1'b0 || D_valid !== 1'b0 || D_instr !== 32'h0) begin
      errors++; $display("FAIL int_bubble got pc=%h bd=%b v=%b want 4180/0/0", D_pc, D_bd, D_valid); end
    checks++; if (D_bubbleCnt !== exp_bubble || D_stallCnt !== exp_stall) begin
      errors++; $display("FAIL int_cnt got b=%0d s=%0d want b=%0d s=%0d", D_bubbleCnt, D_stallCnt, exp_bubble, exp_stall); end
    $display("test_intreq: pc=%h bubbleCnt=%0d", D_pc, D_bubbleCnt);
  endtask

  task automatic test_reset_override();
    reset = 1'b1;
    step();
    exp_stall = 16'h0; exp_bubble = 16'h0;
    checks++; if (D_pc !== 32'h3000 || D_valid !== 1'b0) begin
      errors++; $display("FAIL rst_override got pc=%h v=%b want 3000/0", D_pc, D_valid); end
    checks++; if (D_stallCnt !== 16'h0 || D_bubbleCnt !== 16'h0) begin
      errors++; $display("FAIL rst_override_cnt got %h/%h want 0/0", D_stallCnt, D_bubbleCnt); end
    reset = 1'b0; intReq = 1'b0; flush = 1'b0; stall = 1'b0; F_bd = 1'b0;
    $display("test_reset_override: pc=%h", D_pc);
  endtask

  task automatic test_back_to_back();
    logic [31:0] pcs [3];
    pcs[0] = 32'h3000; pcs[1] = 32'h3004; pcs[2] = 32'h3008;
    for (int i = 0; i < 3; i++) begin
      F_pc = pcs[i]; F_instr = 32'hA000_0000 | pcs[i];
      step();
      checks++; if (D_pc !== pcs[i] || D_instr !== (32'hA000_0000 | pcs[i]) || D_valid !== 1'b1) begin
        errors++; $display("FAIL b2b[%0d] got pc=%h instr=%h v=%b want %h", i, D_pc, D_instr, D_valid, pcs[i]); end
      $display("test_back_to_back[%0d]: pc=%h instr=%h", i, D_pc, D_instr);
    end
  endtask

  task automatic test_saturation();
    stall = 1'b1;
    for (int i = 0; i < 65540; i++) @(posedge clk);
    #1;
    exp_stall = CNT_ON ? 16'hFFFF : 16'h0;
    checks++; if (D_stallCnt !== exp_stall) begin errors++; $display("FAIL sat_cnt got %h want %h", D_stallCnt, exp_stall); end
    step(); step();
    checks++; if (D_stallCnt !== exp_stall || D_pc !== 32'h3008) begin
      errors++; $display("FAIL sat_hold got cnt=%h pc=%h want %h/3008", D_stallCnt, D_pc, exp_stall); end
    stall = 1'b0;
    $display("test_saturation: stallCnt=%h", D_stallCnt);
  endtask

  initial begin
    test_reset();
    test_load();
    test_stall();
    test_exc();
    test_flush_stall();
    test_intreq();
    test_reset_override();
    test_back_to_back();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
